id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Decode stage. It is the consumer (slave) end of the fetch stage's valid/ready packet stream.
- Accepts pc/instruction packets, decodes RV32I fields and immediates, and presents a registered decoded packet downstream to execute.
- Resolves JAL in decode and drives the fetch redirect pair (branch_taken/branch_addr) back to fetch.
- Discards wrong-path packets until the redirect target arrives.

Parameters:
- XLEN, 32, datapath/address width. Only 32 is supported.
- JAL_REDIRECT, 1, 1 = resolve JAL in decode and redirect fetch; 0 = pass JAL through with no redirect.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- valid_i  in  1  fetch packet valid
- ready_o  out  1  decode can accept this cycle
- pc_i  in  32  packet pc
- instr_i  in  32  packet instruction word
- valid_o  out  1  decoded packet valid
- ready_i  in  1  execute accepts decoded packet
- pc_o  out  32  decoded pc
- instr_o  out  32  raw instruction
- opclass_o  out  4  op class (pkg enum)
- rd_o / rs1_o / rs2_o  out  5 each  register indices
- funct3_o  out  3  funct3
- funct7b5_o  out  1  instr[30]
- imm_o  out  32  sign-extended immediate for the format
- illegal_o  out  1  illegal encoding
- misalign_o  out  1  JAL target not 4-byte aligned
- branch_taken_o  out  1  one-cycle redirect pulse to fetch
- branch_addr_o  out  32  redirect target, valid when branch_taken_o=1
- flush_i  in  1  flush from execute (mispredict/trap)

Behaviour:
- Reset: valid_o=0, ready_o=0, branch_taken_o=0. branch_addr_o, pc_o, instr_o, imm_o and all fields = 0. Skid buffer empty, shadow flag clear. ready_o rises on the first clock after rst deasserts.
- Handshake:
  - Input transfer when valid_i&ready_o. Output transfer when valid_o&ready_i.
  - valid_o, once high, holds all outputs stable until ready_i.
- Buffering: output register plus one skid entry.
  - ready_o is registered and equals "skid empty"; it is never combinational on ready_i.
  - Latency: accept at edge N -> valid_o at N+1 when the output register is empty or draining. Otherwise the packet lands in skid and moves to output on the next drain.
  - Full throughput of 1 packet/cycle when ready_i is held high.
- Decode (combinational on the incoming packet, registered with it):
  - Opcode map: 0110011 ALU_R, 0010011 ALU_I, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC, 1110011 SYSTEM, 0001111 FENCE.
  - Anything else, or instr[1:0]!=2'b11, gives opclass ILLEGAL and illegal_o=1.
  - Immediates: I/S/B/U/J formats, sign-extended to 32. B and J have bit0=0. U is {instr[31:12],12'b0}. R gives imm 0.
- JAL redirect (JAL_REDIRECT=1, not in shadow, no flush):
  - On acceptance of a JAL, target = pc_i + J-imm (mod 2^32, wraps).
  - If target[1:0]==0: next cycle branch_taken_o=1 for exactly 1 cycle, branch_addr_o=target, and the shadow flag is set with shadow_pc=target.
  - If target is misaligned: no redirect, misalign_o=1 on that packet.
  - The JAL itself always goes downstream (it writes rd).
- Shadow (wrong-path discard):
  - While set, accepted packets with pc_i!=shadow_pc are dropped. ready_o still accepts them, and they never reach valid_o.
  - The first packet with pc_i==shadow_pc clears shadow and is processed normally. This includes JAL-to-self (offset 0).
  - A JAL arriving in shadow with a matching pc may raise a new redirect.
- flush_i (highest priority):
  - At that edge, clear the output register and skid (valid_o=0 next cycle), clear shadow, and suppress any redirect that would issue.
  - A packet offered in the same cycle is dropped.
  - Flush while branch_taken_o=1 does not extend the pulse.
- Reset mid-operation: all state returns to reset values immediately (asynchronous).

Decomposition:
- Package rv_pkg:
  - opclass enum (4-bit, ILLEGAL=4'hF).
  - Opcode constants.
  - Decoded-packet struct: pc, instr, opclass, rd, rs1, rs2, funct3, funct7b5, imm, illegal, misalign.
  - XLEN constant.
- Sub-module rv_imm_gen: combinational format select and sign-extension from instr/opclass. The decode table stays in id_stage.

Test Plan:
- Stream ADDI x1,x0,5 (0x00500093) at pc 0x0, 0x4, 0x8 with ready_i=1 -> valid_o one cycle after each accept, opclass ALU_I, rd=1, imm=5, no stalls.
- Hold ready_i=0 for 3 cycles with valid_i=1 -> exactly 2 packets buffered, ready_o=0 after the 2nd. Outputs stay stable; on release, packets drain in order with none lost or duplicated.
- JAL x1,+16 (0x010000EF) at pc 0x100, then packets 0x104, 0x108, 0x110 -> branch_taken_o pulse with branch_addr_o=0x110. 0x104 and 0x108 are dropped; 0x110 emerges valid.
- JAL offset 0 at pc 0x200, next packet pc 0x200 -> redirect to 0x200, shadow clears on the next packet, both JALs go downstream.
- flush_i asserted with 2 packets buffered and shadow set -> valid_o=0 next cycle, ready_o=1, next packet at any pc is accepted.
- Word 0x00000000 and opcode 0x7F -> illegal_o=1, opclass ILLEGAL. Separately, rst asserted mid-stream -> outputs return to 0 asynchronously.

Source files
------------

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - RV32I decode types, opcode constants and decoded-packet struct
// Purpose: shared definitions for the decode stage and its immediate generator.
// Ports: none (package).
package rv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    OC_ALU_R   = 4'h0,
    OC_ALU_I   = 4'h1,
    OC_LOAD    = 4'h2,
    OC_STORE   = 4'h3,
    OC_BRANCH  = 4'h4,
    OC_JAL     = 4'h5,
    OC_JALR    = 4'h6,
    OC_LUI     = 4'h7,
    OC_AUIPC   = 4'h8,
    OC_SYSTEM  = 4'h9,
    OC_FENCE   = 4'hA,
    OC_ILLEGAL = 4'hF
  } opclass_e;

  localparam logic [6:0] OP_ALU_R  = 7'b0110011;
  localparam logic [6:0] OP_ALU_I  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    opclass_e        opclass;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [XLEN-1:0] imm;
    logic            illegal;
    logic            misalign;
  } decoded_t;

endpackage

// File: rtl/rv_imm_gen.sv
// rtl/rv_imm_gen.sv - RV32I immediate format select and sign extension
// Purpose: builds the 32-bit immediate for the format implied by the op class.
// Ports:
//   i_instr   in  25  instruction bits [31:7] (opcode bits are not needed)
//   i_opclass in  4   decoded op class
//   o_imm     out 32  sign-extended immediate, 0 for R-type and illegal
module rv_imm_gen
  import rv_pkg::*;
(
  input  logic [31:7] i_instr,
  input  opclass_e    i_opclass,
  output logic [31:0] o_imm
);

  always_comb begin
    o_imm = '0;
    case (i_opclass)
      OC_ALU_I, OC_LOAD, OC_JALR, OC_SYSTEM, OC_FENCE:
        o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      OC_STORE:
        o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      OC_BRANCH:
        o_imm = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
      OC_LUI, OC_AUIPC:
        o_imm = {i_instr[31:12], 12'b0};
      OC_JAL:
        o_imm = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
      default:
        o_imm = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I decode stage with skid buffer, JAL redirect and wrong-path discard
// Purpose: accepts pc/instruction packets from fetch, decodes them and presents a
// registered decoded packet to execute; resolves JAL early and redirects fetch.
// Ports:
//   clk, rst (async, active-high)
//   valid_i/ready_o/pc_i/instr_i        fetch packet stream (consumer side)
//   valid_o/ready_i/pc_o/instr_o/...     decoded packet stream to execute
//   branch_taken_o/branch_addr_o         one-cycle redirect to fetch
//   flush_i                              flush from execute, highest priority
module id_stage #(
  parameter int XLEN         = 32,
  parameter bit JAL_REDIRECT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     instr_o,
  output logic [3:0]      opclass_o,
  output logic [4:0]      rd_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [2:0]      funct3_o,
  output logic            funct7b5_o,
  output logic [XLEN-1:0] imm_o,
  output logic            illegal_o,
  output logic            misalign_o,
  output logic            branch_taken_o,
  output logic [XLEN-1:0] branch_addr_o,
  input  logic            flush_i
);
  import rv_pkg::*;

  opclass_e        w_opclass;
  logic [31:0]     w_imm;
  logic [XLEN-1:0] w_jal_target;
  logic            w_is_jal;
  logic            w_jal_misalign;
  logic            w_accept;
  logic            w_drop;
  logic            w_push;
  logic            w_redirect;
  logic            w_out_free;
  decoded_t        w_dec;

  decoded_t        r_out;
  decoded_t        r_skid;
  logic            r_out_valid;
  logic            r_skid_valid;
  logic            r_ready;
  logic            r_shadow;
  logic [XLEN-1:0] r_shadow_pc;
  logic            r_br_taken;
  logic [XLEN-1:0] r_br_addr;

  // Every legal opcode ends in 2'b11, so a bad instr[1:0] falls to ILLEGAL.
  always_comb begin
    w_opclass = OC_ILLEGAL;
    case (instr_i[6:0])
      OP_ALU_R:  w_opclass = OC_ALU_R;
      OP_ALU_I:  w_opclass = OC_ALU_I;
      OP_LOAD:   w_opclass = OC_LOAD;
      OP_STORE:  w_opclass = OC_STORE;
      OP_BRANCH: w_opclass = OC_BRANCH;
      OP_JAL:    w_opclass = OC_JAL;
      OP_JALR:   w_opclass = OC_JALR;
      OP_LUI:    w_opclass = OC_LUI;
      OP_AUIPC:  w_opclass = OC_AUIPC;
      OP_SYSTEM: w_opclass = OC_SYSTEM;
      OP_FENCE:  w_opclass = OC_FENCE;
      default:   w_opclass = OC_ILLEGAL;
    endcase
  end

  rv_imm_gen u_imm_gen (
    .i_instr   (instr_i[31:7]),
    .i_opclass (w_opclass),
    .o_imm     (w_imm)
  );

  assign w_jal_target   = pc_i + w_imm;
  assign w_is_jal       = JAL_REDIRECT && (w_opclass == OC_JAL);
  assign w_jal_misalign = w_is_jal && (w_jal_target[1:0] != 2'b00);

  // ready_o is registered as "skid empty", so an accept never targets a full skid.
  assign w_accept   = valid_i && r_ready;
  // Wrong-path packets are still accepted (fetch keeps flowing) but discarded here.
  assign w_drop     = r_shadow && (pc_i != r_shadow_pc);
  assign w_push     = w_accept && !w_drop && !flush_i;
  assign w_redirect = w_push && w_is_jal && !w_jal_misalign;
  assign w_out_free = !r_out_valid || ready_i;

  always_comb begin
    w_dec          = '0;
    w_dec.pc       = pc_i;
    w_dec.instr    = instr_i;
    w_dec.opclass  = w_opclass;
    w_dec.rd       = instr_i[11:7];
    w_dec.rs1      = instr_i[19:15];
    w_dec.rs2      = instr_i[24:20];
    w_dec.funct3   = instr_i[14:12];
    w_dec.funct7b5 = instr_i[30];
    w_dec.imm      = w_imm;
    w_dec.illegal  = (w_opclass == OC_ILLEGAL);
    w_dec.misalign = w_jal_misalign;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_ready      <= 1'b0;
      r_shadow     <= 1'b0;
      r_shadow_pc  <= '0;
      r_br_taken   <= 1'b0;
      r_br_addr    <= '0;
    end else if (flush_i) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_ready      <= 1'b1;
      r_shadow     <= 1'b0;
      r_br_taken   <= 1'b0;
    end else begin
      r_br_taken <= w_redirect;
      // A matching JAL inside the shadow re-arms it rather than clearing it.
      if (w_redirect) begin
        r_br_addr   <= w_jal_target;
        r_shadow    <= 1'b1;
        r_shadow_pc <= w_jal_target;
      end else if (w_accept && r_shadow && !w_drop) begin
        r_shadow <= 1'b0;
      end

      if (w_out_free) begin
        // Skid is older than anything arriving now; it drains first.
        if (r_skid_valid) begin
          r_out        <= r_skid;
          r_out_valid  <= 1'b1;
          r_skid_valid <= 1'b0;
        end else begin
          r_out_valid <= w_push;
          if (w_push) begin
            r_out <= w_dec;
          end
        end
        r_ready <= 1'b1;
      end else if (w_push) begin
        r_skid       <= w_dec;
        r_skid_valid <= 1'b1;
        r_ready      <= 1'b0;
      end
    end
  end

  assign ready_o        = r_ready;
  assign valid_o        = r_out_valid;
  assign pc_o           = r_out.pc;
  assign instr_o        = r_out.instr;
  assign opclass_o      = r_out.opclass;
  assign rd_o           = r_out.rd;
  assign rs1_o          = r_out.rs1;
  assign rs2_o          = r_out.rs2;
  assign funct3_o       = r_out.funct3;
  assign funct7b5_o     = r_out.funct7b5;
  assign imm_o          = r_out.imm;
  assign illegal_o      = r_out.illegal;
  assign misalign_o     = r_out.misalign;
  assign branch_taken_o = r_br_taken;
  assign branch_addr_o  = r_br_addr;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - self-checking bench for id_stage
module tb_id_stage;
  import rv_pkg::*;

  localparam logic [31:0] ADDI  = 32'h00500093;
  localparam logic [31:0] JAL16 = 32'h010000EF;
  localparam logic [31:0] JAL0  = 32'h000000EF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] pc_i = '0;
  logic [31:0] instr_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic [3:0]  opclass_o;
  logic [4:0]  rd_o, rs1_o, rs2_o;
  logic [2:0]  funct3_o;
  logic        funct7b5_o;
  logic [31:0] imm_o;
  logic        illegal_o;
  logic        misalign_o;
  logic        branch_taken_o;
  logic [31:0] branch_addr_o;
  logic        flush_i = 1'b0;

  always #5 clk = ~clk;

  id_stage #(.XLEN(32), .JAL_REDIRECT(1'b1)) dut (
    .clk(clk), .rst(rst),
    .valid_i(valid_i), .ready_o(ready_o), .pc_i(pc_i), .instr_i(instr_i),
    .valid_o(valid_o), .ready_i(ready_i), .pc_o(pc_o), .instr_o(instr_o),
    .opclass_o(opclass_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .funct3_o(funct3_o), .funct7b5_o(funct7b5_o), .imm_o(imm_o),
    .illegal_o(illegal_o), .misalign_o(misalign_o),
    .branch_taken_o(branch_taken_o), .branch_addr_o(branch_addr_o),
    .flush_i(flush_i)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] imm;
    logic [3:0]  opc;
    logic        illegal;
    logic        misalign;
  } exp_t;

  // Reference state: packets accepted but not yet taken by execute, in order.
  exp_t        q[$];
  bit          m_shadow = 0;
  logic [31:0] m_spc = '0;
  bit          m_br = 0;
  logic [31:0] m_br_addr = '0;
  bit          m_armed = 0;
  bit          hold_prev = 0;
  logic [95:0] prev_hold = '0;

  function automatic logic [31:0] imm_i(input logic [31:0] w);
    int v;
    v = $signed(w) >>> 20;
    return v;
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] w);
    int v;
    v = $signed(w) >>> 25;
    return v * 32 + int'(w[11:7]);
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] w);
    return (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] w);
    return (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
  endfunction

  function automatic exp_t model(input logic [31:0] pc, input logic [31:0] w);
    exp_t e;
    e.pc = pc; e.instr = w; e.imm = 0; e.illegal = 0; e.misalign = 0;
    case (w[6:0])
      7'b0110011: e.opc = OC_ALU_R;
      7'b0010011: begin e.opc = OC_ALU_I;   e.imm = imm_i(w); end
      7'b0000011: begin e.opc = OC_LOAD;    e.imm = imm_i(w); end
      7'b0100011: begin e.opc = OC_STORE;   e.imm = imm_s(w); end
      7'b1100011: begin e.opc = OC_BRANCH;  e.imm = imm_b(w); end
      7'b1101111: begin e.opc = OC_JAL;     e.imm = imm_j(w); end
      7'b1100111: begin e.opc = OC_JALR;    e.imm = imm_i(w); end
      7'b0110111: begin e.opc = OC_LUI;     e.imm = w & 32'hFFFFF000; end
      7'b0010111: begin e.opc = OC_AUIPC;   e.imm = w & 32'hFFFFF000; end
      7'b1110011: begin e.opc = OC_SYSTEM;  e.imm = imm_i(w); end
      7'b0001111: begin e.opc = OC_FENCE;   e.imm = imm_i(w); end
      default:    begin e.opc = OC_ILLEGAL; e.illegal = 1; end
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [0:13];
    logic [31:0] r;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111,
            7'b1110011, 7'b0001111, 7'h7F, 7'b0010001};
    r = $urandom();
    return {r[31:7], ops[$urandom_range(0, 13)]};
  endfunction

  // Scoreboard: compares the DUT against the model once per cycle.
  initial begin
    exp_t        e;
    logic [31:0] tgt;
    logic [120:0] got, want;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete(); m_shadow = 0; m_br = 0; m_armed = 0; hold_prev = 0;
      end else begin
        n_vec++;
        if (ready_o !== (m_armed && q.size() <= 1)) begin
          n_err++; $display("FAIL ready_o got=%b exp=%b buffered=%0d", ready_o, (m_armed && q.size() <= 1), q.size());
        end
        n_vec++;
        if (valid_o !== (q.size() > 0)) begin
          n_err++; $display("FAIL valid_o got=%b exp=%b", valid_o, (q.size() > 0));
        end
        n_vec++;
        if (branch_taken_o !== m_br) begin
          n_err++; $display("FAIL branch_taken got=%b exp=%b", branch_taken_o, m_br);
        end
        if (m_br) begin
          n_vec++;
          if (branch_addr_o !== m_br_addr) begin
            n_err++; $display("FAIL branch_addr got=%h exp=%h", branch_addr_o, m_br_addr);
          end
        end
        if (hold_prev) begin
          n_vec++;
          if ({pc_o, instr_o, imm_o} !== prev_hold) begin
            n_err++; $display("FAIL hold_stable got=%h exp=%h", {pc_o, instr_o, imm_o}, prev_hold);
          end
        end
        if (valid_o && ready_i) begin
          n_vec++;
          if (q.size() == 0) begin
            n_err++; $display("FAIL spurious_out got pc=%h exp=none", pc_o);
          end else begin
            e = q.pop_front();
            got  = {pc_o, instr_o, opclass_o, imm_o, illegal_o, misalign_o,
                    rd_o, rs1_o, rs2_o, funct3_o, funct7b5_o};
            want = {e.pc, e.instr, e.opc, e.imm, e.illegal, e.misalign,
                    e.instr[11:7], e.instr[19:15], e.instr[24:20], e.instr[14:12], e.instr[30]};
            if (got !== want) begin
              n_err++; $display("FAIL out_packet got=%h exp=%h", got, want);
            end
          end
        end
        hold_prev = valid_o && !ready_i && !flush_i;
        prev_hold = {pc_o, instr_o, imm_o};
        m_armed = 1;
        m_br = 0;
        if (flush_i) begin
          q.delete(); m_shadow = 0;
        end else if (valid_i && ready_o) begin
          if (!(m_shadow && pc_i != m_spc)) begin
            m_shadow = 0;
            e = model(pc_i, instr_i);
            if (e.opc == OC_JAL) begin
              tgt = pc_i + e.imm;
              if (tgt % 4 == 0) begin
                m_br = 1; m_br_addr = tgt; m_shadow = 1; m_spc = tgt;
              end else begin
                e.misalign = 1;
              end
            end
            q.push_back(e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers a packet and holds it until accepted, bounded.
  task automatic send(input logic [31:0] pc, input logic [31:0] w, input bit rnd_ready);
    bit acc;
    valid_i = 1; pc_i = pc; instr_i = w;
    for (int k = 0; k < 64; k++) begin
      if (rnd_ready) ready_i = ($urandom_range(0, 3) != 0);
      acc = ready_o;
      tick();
      if (acc) begin
        valid_i = 0;
        return;
      end
    end
    n_vec++; n_err++;
    $display("FAIL send_timeout pc=%h got=not_accepted exp=accepted", pc);
    valid_i = 0;
  endtask

  task automatic test_reset();
    rst = 1; valid_i = 0; ready_i = 0; flush_i = 0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({valid_o, ready_o, branch_taken_o} !== 3'b000) begin
      n_err++; $display("FAIL rst_ctrl got=%b exp=000", {valid_o, ready_o, branch_taken_o});
    end
    n_vec++;
    if ({pc_o, instr_o, imm_o, branch_addr_o, opclass_o, rd_o, illegal_o, misalign_o} !== '0) begin
      n_err++; $display("FAIL rst_fields got=%h exp=0", {pc_o, instr_o, imm_o, branch_addr_o});
    end
    rst = 0;
    @(negedge clk);
    n_vec++;
    if (ready_o !== 1'b0) begin
      n_err++; $display("FAIL rst_ready_early got=%b exp=0", ready_o);
    end
    tick();
    n_vec++;
    if (ready_o !== 1'b1) begin
      n_err++; $display("FAIL rst_ready_rise got=%b exp=1", ready_o);
    end
  endtask

  task automatic test_stream();
    int c0;
    ready_i = 1;
    c0 = cyc;
    send(32'h0, ADDI, 0);
    send(32'h4, ADDI, 0);
    send(32'h8, ADDI, 0);
    n_vec++;
    if (cyc - c0 !== 3) begin
      n_err++; $display("FAIL stream_cycles got=%0d exp=3", cyc - c0);
    end
    @(negedge clk);
    n_vec++;
    if ({valid_o, pc_o, opclass_o, rd_o, imm_o} !== {1'b1, 32'h8, OC_ALU_I, 5'd1, 32'd5}) begin
      n_err++; $display("FAIL stream_last got=%b/%h/%h/%0d/%0d exp=1/8/1/1/5", valid_o, pc_o, opclass_o, rd_o, imm_o);
    end
    tick();
  endtask

  task automatic test_backpressure();
    ready_i = 0;
    send(32'h10, ADDI, 0);
    send(32'h14, ADDI, 0);
    valid_i = 1; pc_i = 32'h18; instr_i = ADDI;
    @(negedge clk);
    n_vec++;
    if ({ready_o, valid_o, pc_o} !== {1'b0, 1'b1, 32'h10}) begin
      n_err++; $display("FAIL bp_full got=%b/%b/%h exp=0/1/10", ready_o, valid_o, pc_o);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if ({ready_o, pc_o} !== {1'b0, 32'h10}) begin
      n_err++; $display("FAIL bp_hold got=%b/%h exp=0/10", ready_o, pc_o);
    end
    tick();
    ready_i = 1;
    send(32'h18, ADDI, 0);
    repeat (4) tick();
  endtask

  task automatic test_jal_redirect();
    ready_i = 1;
    send(32'h100, JAL16, 0);
    @(negedge clk);
    n_vec++;
    if ({branch_taken_o, branch_addr_o} !== {1'b1, 32'h110}) begin
      n_err++; $display("FAIL jal_pulse got=%b/%h exp=1/110", branch_taken_o, branch_addr_o);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if (branch_taken_o !== 1'b0) begin
      n_err++; $display("FAIL jal_pulse_len got=%b exp=0", branch_taken_o);
    end
    tick();
    send(32'h104, ADDI, 0);
    send(32'h108, ADDI, 0);
    send(32'h110, ADDI, 0);
    @(negedge clk);
    n_vec++;
    if ({valid_o, pc_o} !== {1'b1, 32'h110}) begin
      n_err++; $display("FAIL jal_target_out got=%b/%h exp=1/110", valid_o, pc_o);
    end
    tick();
  endtask

  task automatic test_jal_self();
    ready_i = 1;
    send(32'h200, JAL0, 0);
    @(negedge clk);
    n_vec++;
    if ({branch_taken_o, branch_addr_o} !== {1'b1, 32'h200}) begin
      n_err++; $display("FAIL jal0_pulse got=%b/%h exp=1/200", branch_taken_o, branch_addr_o);
    end
    tick();
    send(32'h200, JAL0, 0);
    @(negedge clk);
    n_vec++;
    if ({branch_taken_o, valid_o, opclass_o} !== {1'b1, 1'b1, OC_JAL}) begin
      n_err++; $display("FAIL jal0_again got=%b/%b/%h exp=1/1/5", branch_taken_o, valid_o, opclass_o);
    end
    tick();
    send(32'h200, ADDI, 0);
    send(32'h204, ADDI, 0);
    @(negedge clk);
    n_vec++;
    if ({valid_o, pc_o} !== {1'b1, 32'h204}) begin
      n_err++; $display("FAIL jal0_clear got=%b/%h exp=1/204", valid_o, pc_o);
    end
    tick();
  endtask

  task automatic test_flush();
    ready_i = 0;
    send(32'h2F8, ADDI, 0);
    send(32'h2FC, JAL16, 0);
    flush_i = 1;
    tick();
    flush_i = 0;
    @(negedge clk);
    n_vec++;
    if ({valid_o, ready_o, branch_taken_o} !== 3'b010) begin
      n_err++; $display("FAIL flush_state got=%b exp=010", {valid_o, ready_o, branch_taken_o});
    end
    tick();
    ready_i = 1; flush_i = 1; valid_i = 1; pc_i = 32'h404; instr_i = ADDI;
    tick();
    flush_i = 0; valid_i = 0;
    @(negedge clk);
    n_vec++;
    if (valid_o !== 1'b0) begin
      n_err++; $display("FAIL flush_drop got=%b exp=0", valid_o);
    end
    tick();
    send(32'h500, ADDI, 0);
    @(negedge clk);
    n_vec++;
    if ({valid_o, pc_o} !== {1'b1, 32'h500}) begin
      n_err++; $display("FAIL flush_after got=%b/%h exp=1/500", valid_o, pc_o);
    end
    tick();
  endtask

  task automatic test_illegal();
    ready_i = 1;
    send(32'h600, 32'h00000000, 0);
    @(negedge clk);
    n_vec++;
    if ({valid_o, illegal_o, opclass_o} !== {1'b1, 1'b1, 4'hF}) begin
      n_err++; $display("FAIL illegal_zero got=%b/%b/%h exp=1/1/f", valid_o, illegal_o, opclass_o);
    end
    tick();
    send(32'h604, 32'h0000007F, 0);
    @(negedge clk);
    n_vec++;
    if ({valid_o, illegal_o, opclass_o} !== {1'b1, 1'b1, 4'hF}) begin
      n_err++; $display("FAIL illegal_7f got=%b/%b/%h exp=1/1/f", valid_o, illegal_o, opclass_o);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] nxt_pc;
    logic [31:0] pc;
    int r;
    nxt_pc = 32'h1000;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        flush_i = 1; valid_i = $urandom_range(0, 1);
        pc_i = nxt_pc; instr_i = rand_instr();
        ready_i = $urandom_range(0, 1);
        tick();
        flush_i = 0; valid_i = 0;
        nxt_pc = $urandom() & 32'hFFFFFFFC;
      end else if (r == 1) begin
        ready_i = $urandom_range(0, 1);
        tick();
      end else begin
        pc = (m_shadow && $urandom_range(0, 2) != 0) ? m_spc : nxt_pc;
        send(pc, rand_instr(), 1);
        nxt_pc = pc + 4;
      end
    end
    ready_i = 1;
    repeat (4) tick();
    @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_err++; $display("FAIL random_drain got=%0d_left exp=0", q.size());
    end
    tick();
  endtask

  task automatic test_reset_mid();
    ready_i = 0;
    send(32'h700, ADDI, 0);
    send(32'h704, JAL16, 0);
    #2;
    rst = 1;
    #1;
    n_vec++;
    if ({valid_o, ready_o, branch_taken_o, pc_o, instr_o, imm_o, rd_o} !== '0) begin
      n_err++; $display("FAIL rst_async got=%b/%b/%b/%h/%h exp=0", valid_o, ready_o, branch_taken_o, pc_o, instr_o);
    end
    @(posedge clk);
    #1;
    rst = 0;
    ready_i = 1;
    send(32'h800, ADDI, 0);
    @(negedge clk);
    n_vec++;
    if ({valid_o, pc_o} !== {1'b1, 32'h800}) begin
      n_err++; $display("FAIL rst_resume got=%b/%h exp=1/800", valid_o, pc_o);
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_jal_redirect();
    test_jal_self();
    test_flush();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
